// File: rtl/vec_hazard_ctrl.sv
// Hazard and forwarding controller for the ID->EX->MEM->WB vector pipeline.
// Produces registered execVect forward selects plus a one-cycle load-use stall.
module vec_hazard_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_ra1,
   input  logic [ADDR_W-1:0] id_ra2,
   input  logic [ADDR_W-1:0] id_ra3,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic              id_use3,
   input  logic              id_immSrc,
   input  logic              id_fb_dec,
   input  logic              id_wr,
   input  logic [ADDR_W-1:0] id_wa,
   input  logic              id_is_load,
   input  logic              flush,
   input  logic              mem_busy,
   output logic              Fa,
   output logic              Fb,
   output logic              Fc,
   output logic              sel1,
   output logic              sel2,
   output logic              sel3,
   output logic              stall_id,
   output logic              ex_valid
);

   localparam logic RUN     = 1'b0;
   localparam logic LDSTALL = 1'b1;

   logic              state_q, state_d;
   logic              ex_valid_q, ex_valid_d;
   logic              ex_wr_q, ex_wr_d;
   logic [ADDR_W-1:0] ex_wa_q, ex_wa_d;
   logic              ex_ld_q, ex_ld_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_wa_q, mem_wa_d;
   logic              fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;
   logic              sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d;

   logic m1e, m2e, m3e, m1m, m2m, m3m;
   logic f1e, f2e, f3e;
   logic load_stall;

   // WB results reach ID through register-file write-before-read, so no WB
   // tracker is needed; MEM load status is irrelevant once the data is ready.
   function automatic logic src_match(input logic use_i, input logic [ADDR_W-1:0] ra,
                                      input logic v, input logic wr,
                                      input logic [ADDR_W-1:0] wa);
      return use_i && v && wr && (wa == ra) && !((ZERO_REG == 1) && (ra == '0));
   endfunction

   always_comb begin
      m1e = src_match(id_use1, id_ra1, ex_valid_q, ex_wr_q, ex_wa_q);
      m2e = src_match(id_use2, id_ra2, ex_valid_q, ex_wr_q, ex_wa_q);
      m3e = src_match(id_use3, id_ra3, ex_valid_q, ex_wr_q, ex_wa_q);
      m1m = src_match(id_use1, id_ra1, mem_valid_q, mem_wr_q, mem_wa_q);
      m2m = src_match(id_use2, id_ra2, mem_valid_q, mem_wr_q, mem_wa_q);
      m3m = src_match(id_use3, id_ra3, mem_valid_q, mem_wr_q, mem_wa_q);
      // A load in EX cannot forward; it is handled by the stall instead.
      f1e = m1e && !ex_ld_q;
      f2e = m2e && !ex_ld_q;
      f3e = m3e && !ex_ld_q;
      load_stall = (state_q == RUN) && id_valid && !flush && ex_ld_q &&
                   (m1e || m2e || m3e);
      stall_id = mem_busy || load_stall;
   end

   always_comb begin
      state_d     = state_q;
      ex_valid_d  = ex_valid_q;
      ex_wr_d     = ex_wr_q;
      ex_wa_d     = ex_wa_q;
      ex_ld_d     = ex_ld_q;
      mem_valid_d = mem_valid_q;
      mem_wr_d    = mem_wr_q;
      mem_wa_d    = mem_wa_q;
      fa_d   = fa_q;
      fb_d   = fb_q;
      fc_d   = fc_q;
      sel1_d = sel1_q;
      sel2_d = sel2_q;
      sel3_d = sel3_q;
      if (!mem_busy) begin
         mem_valid_d = ex_valid_q;
         mem_wr_d    = ex_wr_q;
         mem_wa_d    = ex_wa_q;
         ex_valid_d  = 1'b0;
         ex_wr_d     = 1'b0;
         ex_wa_d     = '0;
         ex_ld_d     = 1'b0;
         fa_d   = 1'b0;
         fb_d   = 1'b0;
         fc_d   = 1'b0;
         sel1_d = 1'b0;
         sel2_d = 1'b0;
         sel3_d = 1'b0;
         state_d = load_stall ? LDSTALL : RUN;
         if (!flush && !load_stall && id_valid) begin
            ex_valid_d = 1'b1;
            ex_wr_d    = id_wr;
            ex_wa_d    = id_wa;
            ex_ld_d    = id_is_load;
            fa_d   = f1e || m1m;
            sel1_d = !f1e && m1m;
            fb_d   = id_immSrc ? id_fb_dec : (f2e || m2m);
            sel2_d = !id_immSrc && !f2e && m2m;
            fc_d   = f3e || m3m;
            sel3_d = !f3e && m3m;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         ex_valid_q  <= 1'b0;
         ex_wr_q     <= 1'b0;
         ex_wa_q     <= '0;
         ex_ld_q     <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wa_q    <= '0;
         fa_q   <= 1'b0;
         fb_q   <= 1'b0;
         fc_q   <= 1'b0;
         sel1_q <= 1'b0;
         sel2_q <= 1'b0;
         sel3_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ex_valid_q  <= ex_valid_d;
         ex_wr_q     <= ex_wr_d;
         ex_wa_q     <= ex_wa_d;
         ex_ld_q     <= ex_ld_d;
         mem_valid_q <= mem_valid_d;
         mem_wr_q    <= mem_wr_d;
         mem_wa_q    <= mem_wa_d;
         fa_q   <= fa_d;
         fb_q   <= fb_d;
         fc_q   <= fc_d;
         sel1_q <= sel1_d;
         sel2_q <= sel2_d;
         sel3_q <= sel3_d;
      end
   end

   assign Fa       = fa_q;
   assign Fb       = fb_q;
   assign Fc       = fc_q;
   assign sel1     = sel1_q;
   assign sel2     = sel2_q;
   assign sel3     = sel3_q;
   assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_vec_hazard_ctrl.sv
// Directed bench for vec_hazard_ctrl: forwarding, load-use stall, freeze,
// flush, zero register and asynchronous reset.
module tb_vec_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_ra1, id_ra2, id_ra3, id_wa;
   logic       id_use1, id_use2, id_use3;
   logic       id_immSrc, id_fb_dec, id_wr, id_is_load;
   logic       flush, mem_busy;
   logic       Fa, Fb, Fc, sel1, sel2, sel3, stall_id, ex_valid;

   int n_cmp = 0;
   int n_err = 0;

   vec_hazard_ctrl #(.ADDR_W(4), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_ra1(id_ra1), .id_ra2(id_ra2), .id_ra3(id_ra3),
      .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
      .id_immSrc(id_immSrc), .id_fb_dec(id_fb_dec), .id_wr(id_wr),
      .id_wa(id_wa), .id_is_load(id_is_load), .flush(flush),
      .mem_busy(mem_busy), .Fa(Fa), .Fb(Fb), .Fc(Fc),
      .sel1(sel1), .sel2(sel2), .sel3(sel3),
      .stall_id(stall_id), .ex_valid(ex_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Checks the registered EX outputs in one call.
   task automatic chk_ex(input string tag, input logic v, input logic fa, input logic s1,
                         input logic fb, input logic s2, input logic fc, input logic s3);
      chk({tag, ".ex_valid"}, ex_valid, v);
      chk({tag, ".Fa"}, Fa, fa);
      chk({tag, ".sel1"}, sel1, s1);
      chk({tag, ".Fb"}, Fb, fb);
      chk({tag, ".sel2"}, sel2, s2);
      chk({tag, ".Fc"}, Fc, fc);
      chk({tag, ".sel3"}, sel3, s3);
   endtask

   task automatic drive(input logic v, input logic [3:0] ra1, input logic u1,
                        input logic [3:0] ra2, input logic u2, input logic imm,
                        input logic fbd, input logic wr, input logic [3:0] wa,
                        input logic ld);
      id_valid = v;  id_ra1 = ra1; id_use1 = u1;
      id_ra2 = ra2;  id_use2 = u2; id_immSrc = imm; id_fb_dec = fbd;
      id_ra3 = 4'd0; id_use3 = 1'b0;
      id_wr = wr;    id_wa = wa;   id_is_load = ld;
   endtask

   task automatic nop();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; mem_busy = 1'b0;
      nop();
      #12;
      chk_ex("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.stall_id", stall_id, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Back-to-back ALU dependence on v3
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
      #1 chk("b2b.i0.stall", stall_id, 1'b0);
      tick();
      chk_ex("b2b.i0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      #1 chk("b2b.i1.stall", stall_id, 1'b0);
      tick();
      chk_ex("b2b.i1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Distance-2 dependence on v4 across a NOP
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
      tick();
      nop();
      tick();
      chk("d2.nop.ex_valid", ex_valid, 1'b0);
      drive(1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      chk_ex("d2.i2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Load-use on v6
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
      #1 chk("ld.ld.stall", stall_id, 1'b0);
      tick();
      drive(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      #1 chk("ld.use.stall", stall_id, 1'b1);
      tick();
      chk_ex("ld.bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ld.ldstall.stall", stall_id, 1'b0);
      tick();
      chk_ex("ld.add", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nop();
      #1 chk("ld.after.stall", stall_id, 1'b0);

      // Immediate operand 2, then zero operand request
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      tick();
      drive(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      chk_ex("imm.fb0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
      tick();
      drive(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      tick();
      chk_ex("imm.fb1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Zero register is never forwarded
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
      tick();
      drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      chk_ex("zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush a dependent instruction; producer still advances into MEM
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
      tick();
      drive(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      flush = 1'b1;
      #1 chk("flush.stall", stall_id, 1'b0);
      tick();
      flush = 1'b0;
      chk_ex("flush.bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_ex("flush.next", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Freeze during a load-use stall, then reset mid-LDSTALL
      drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
      tick();
      drive(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
      tick();
      chk_ex("frz.ld", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("frz.busy.stall", stall_id, 1'b1);
         tick();
         chk_ex("frz.hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      mem_busy = 1'b0;
      #1 chk("frz.ldstall.stall", stall_id, 1'b1);
      tick();
      chk_ex("frz.bubble", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("frz.ldstall.stall_id", stall_id, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk_ex("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.mid.stall", stall_id, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rst.after.stall", stall_id, 1'b0);
      tick();
      chk_ex("rst.after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
